// File: rtl/cfu_pkg.sv
// rtl/cfu_pkg.sv - shared constants and FSM state type for the SIMD MAC CFU
//
// Purpose: function-code decode constants, arithmetic widths of the dot
// product lanes, and the controller state enum.
// Ports: none (package).
package cfu_pkg;

  // funct7 groups
  localparam logic [6:0] F7_NOP  = 7'd0;
  localparam logic [6:0] F7_CFG  = 7'd1;
  localparam logic [6:0] F7_COMP = 7'd2;
  localparam logic [6:0] F7_BANK = 7'd3;

  // funct3 codes within each group
  localparam logic [2:0] F3_NOP        = 3'd0;
  localparam logic [2:0] F3_SET_FILTER = 3'd0;
  localparam logic [2:0] F3_SET_OFFSET = 3'd1;
  localparam logic [2:0] F3_SET_CFG    = 3'd2;
  localparam logic [2:0] F3_STATUS     = 3'd3;
  localparam logic [2:0] F3_MAC        = 3'd0;
  localparam logic [2:0] F3_DOT        = 3'd1;
  localparam logic [2:0] F3_READ       = 3'd0;
  localparam logic [2:0] F3_READ_CLR   = 3'd1;
  localparam logic [2:0] F3_CLEAR_ALL  = 3'd2;
  localparam logic [2:0] F3_WRITE      = 3'd3;

  // Offset register width, offset-adjusted lane width and lane product width
  localparam int OFFSET_W   = 9;
  localparam int OFF_LANE_W = 10;
  localparam int PROD_W     = 18;

  typedef enum logic [2:0] {
    ST_INIT_CLR,
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR,
    ST_RESP
  } state_e;

endpackage

// File: rtl/cfu_simd_dot.sv
// rtl/cfu_simd_dot.sv - combinational signed SIMD dot product with input offset
//
// Purpose: sum over lanes of (sext(a[k]) + offset) * filter[k].
// Ports:
//   a      in  LANES*ELEM_W  packed signed activations
//   filter in  LANES*ELEM_W  packed signed filter elements
//   offset in  OFFSET_W      signed input offset
//   dot    out 32            sign-extended sum of lane products
module cfu_simd_dot
  import cfu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int ELEM_W = 8
) (
  input  logic [LANES*ELEM_W-1:0] a,
  input  logic [LANES*ELEM_W-1:0] filter,
  input  logic [OFFSET_W-1:0]     offset,
  output logic [31:0]             dot
);

  always_comb begin
    logic signed [ELEM_W-1:0]     a_e;
    logic signed [ELEM_W-1:0]     f_e;
    logic signed [OFFSET_W-1:0]   off_s;
    logic signed [OFF_LANE_W-1:0] lane_in;
    logic signed [PROD_W-1:0]     prod;
    logic signed [31:0]           sum;
    off_s   = offset;
    a_e     = '0;
    f_e     = '0;
    lane_in = '0;
    prod    = '0;
    sum     = '0;
    for (int k = 0; k < LANES; k++) begin
      a_e     = a[k*ELEM_W +: ELEM_W];
      f_e     = filter[k*ELEM_W +: ELEM_W];
      // Both casts sign-extend because the operands are signed.
      lane_in = OFF_LANE_W'(a_e) + OFF_LANE_W'(off_s);
      prod    = PROD_W'(lane_in) * PROD_W'(f_e);
      sum     = sum + 32'(prod);
    end
    dot = sum;
  end

endmodule

// File: rtl/cfu_simd_mac_acc.sv
// rtl/cfu_simd_mac_acc.sv - CFU: SIMD dot product accumulating into an indexed bank
//
// Purpose: decodes CFU commands, computes offset dot products, accumulates
// into a single-port accumulator RAM with optional saturation and sticky
// overflow, and zeroes the bank one entry per cycle on reset and clear-all.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   cmd_valid / cmd_ready        command handshake
//   cmd_payload_function_id      {funct7, funct3}
//   cmd_payload_inputs_0         operand A (packed elements or data)
//   cmd_payload_inputs_1         operand B (accumulator index, low AW bits)
//   rsp_valid / rsp_ready        response handshake
//   rsp_payload_outputs_0        result
module cfu_simd_mac_acc
  import cfu_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int ELEM_W       = 8,
  parameter int ACC_DEPTH    = 1024,
  parameter int INPUT_OFFSET = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int AW = $clog2(ACC_DEPTH);

  state_e              state_q, state_d;
  logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
  logic [31:0]         filter_q, filter_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic                sat_q, sat_d;
  logic                ovf_q, ovf_d;
  logic [9:0]          op_q, op_d;
  logic [31:0]         a_q, a_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [31:0]         dot_q, dot_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_data_q, rsp_data_d;

  logic [31:0]   acc_mem [ACC_DEPTH];
  logic [31:0]   rd_data_q;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;

  logic [31:0] dot_w;
  logic [31:0] sum_wrap;
  logic        ovf_add;
  logic [31:0] mac_res;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic        unused_idx_hi;

  assign f7            = cmd_payload_function_id[9:3];
  assign f3            = cmd_payload_function_id[2:0];
  assign unused_idx_hi = ^cmd_payload_inputs_1[31:AW];

  cfu_simd_dot #(
    .LANES  (LANES),
    .ELEM_W (ELEM_W)
  ) u_dot (
    .a      (cmd_payload_inputs_0),
    .filter (filter_q),
    .offset (offset_q),
    .dot    (dot_w)
  );

  // Overflow: operands share a sign and the wrapped sum does not.
  always_comb begin
    sum_wrap = rd_data_q + dot_q;
    ovf_add  = (rd_data_q[31] == dot_q[31]) && (sum_wrap[31] != rd_data_q[31]);
    if (ovf_add && sat_q) begin
      mac_res = rd_data_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      mac_res = sum_wrap;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    filter_d   = filter_q;
    offset_d   = offset_q;
    sat_d      = sat_q;
    ovf_d      = ovf_q;
    op_d       = op_q;
    a_d        = a_q;
    idx_d      = idx_q;
    dot_d      = dot_q;
    rsp_data_d = rsp_data_q;
    // In IDLE the RAM address follows the offered index so the entry is
    // already read out by the time EXEC runs.
    mem_addr   = cmd_payload_inputs_1[AW-1:0];
    mem_we     = 1'b0;
    mem_wdata  = '0;

    unique case (state_q)
      ST_INIT_CLR, ST_CLEAR: begin
        mem_addr  = clr_cnt_q;
        mem_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(ACC_DEPTH - 1)) begin
          clr_cnt_d = '0;
          if (state_q == ST_CLEAR) begin
            state_d    = ST_RESP;
            rsp_data_d = 32'(ACC_DEPTH);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_payload_function_id;
          a_d        = cmd_payload_inputs_0;
          idx_d      = cmd_payload_inputs_1[AW-1:0];
          dot_d      = dot_w;
          rsp_data_d = '0;
          state_d    = ST_RESP;
          case (f7)
            F7_CFG: begin
              case (f3)
                F3_SET_FILTER: filter_d = cmd_payload_inputs_0;
                F3_SET_OFFSET: offset_d = cmd_payload_inputs_0[OFFSET_W-1:0];
                F3_SET_CFG:    sat_d    = cmd_payload_inputs_0[0];
                F3_STATUS: begin
                  rsp_data_d = {31'b0, ovf_q};
                  ovf_d      = 1'b0;
                end
                default: ;
              endcase
            end
            F7_COMP: begin
              if (f3 == F3_MAC) state_d = ST_EXEC;
              else if (f3 == F3_DOT) rsp_data_d = dot_w;
            end
            F7_BANK: begin
              if (f3 == F3_READ || f3 == F3_READ_CLR || f3 == F3_WRITE) begin
                state_d = ST_EXEC;
              end else if (f3 == F3_CLEAR_ALL) begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
              end
            end
            default: ;
          endcase
        end
      end

      ST_EXEC: begin
        mem_addr = idx_q;
        state_d  = ST_RESP;
        case (op_q)
          {F7_COMP, F3_MAC}: begin
            mem_we     = 1'b1;
            mem_wdata  = mac_res;
            rsp_data_d = mac_res;
            if (ovf_add) ovf_d = 1'b1;
          end
          {F7_BANK, F3_READ}: rsp_data_d = rd_data_q;
          {F7_BANK, F3_READ_CLR}: begin
            rsp_data_d = rd_data_q;
            mem_we     = 1'b1;
          end
          {F7_BANK, F3_WRITE}: begin
            mem_we     = 1'b1;
            mem_wdata  = a_q;
            rsp_data_d = '0;
          end
          default: ;
        endcase
      end

      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_INIT_CLR;
    endcase

    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT_CLR;
      clr_cnt_q   <= '0;
      filter_q    <= '0;
      offset_q    <= OFFSET_W'(INPUT_OFFSET);
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      idx_q       <= '0;
      dot_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      filter_q    <= filter_d;
      offset_q    <= offset_d;
      sat_q       <= sat_d;
      ovf_q       <= ovf_d;
      op_q        <= op_d;
      a_q         <= a_d;
      idx_q       <= idx_d;
      dot_q       <= dot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Single-port read-first RAM; contents come from the clear sequences.
  always_ff @(posedge clk) begin
    if (mem_we) acc_mem[mem_addr] <= mem_wdata;
    rd_data_q <= acc_mem[mem_addr];
  end

  assign cmd_ready             = (state_q == ST_IDLE);
  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;

endmodule

// File: tb/tb_cfu_simd_mac_acc.sv
// tb/tb_cfu_simd_mac_acc.sv - self-checking bench for cfu_simd_mac_acc
module tb_cfu_simd_mac_acc;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  fid = '0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_payload;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_acc [D];
  logic [31:0] m_filter;
  int          m_offset;
  bit          m_sat;
  bit          m_ovf;

  always #5 clk = ~clk;

  cfu_simd_mac_acc #(.LANES(4), .ELEM_W(8), .ACC_DEPTH(D), .INPUT_OFFSET(128)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload)
  );

  function automatic logic [9:0] id(input int f7, input int f3);
    return {7'(f7), 3'(f3)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < D; i++) m_acc[i] = 0;
    m_filter = 32'h0;
    m_offset = 128;
    m_sat    = 1'b0;
    m_ovf    = 1'b0;
  endfunction

  function automatic int m_dot(input logic [31:0] a);
    int s = 0;
    for (int k = 0; k < 4; k++) begin
      int av = $signed(a[k*8 +: 8]);
      int fv = $signed(m_filter[k*8 +: 8]);
      s += (av + m_offset) * fv;
    end
    return s;
  endfunction

  // Applies one command to the model; returns expected result and latency.
  function automatic void m_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    int f7 = int'(f[9:3]);
    int f3 = int'(f[2:0]);
    int ix = int'(b[3:0]);
    longint s;
    r = 0;
    lat = 1;
    if (f7 == 1) begin
      if (f3 == 0) m_filter = a;
      else if (f3 == 1) m_offset = $signed(a[8:0]);
      else if (f3 == 2) m_sat = a[0];
      else if (f3 == 3) begin r = 32'(m_ovf); m_ovf = 0; end
    end else if (f7 == 2 && f3 == 0) begin
      lat = 2;
      s = longint'(m_acc[ix]) + longint'(m_dot(a));
      if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
        m_ovf = 1;
        if (m_sat) s = (s > 0) ? 64'sd2147483647 : -64'sd2147483648;
      end
      m_acc[ix] = int'(s);
      r = m_acc[ix];
    end else if (f7 == 2 && f3 == 1) begin
      r = m_dot(a);
    end else if (f7 == 3 && f3 <= 3) begin
      lat = 2;
      if (f3 == 0) r = m_acc[ix];
      else if (f3 == 1) begin r = m_acc[ix]; m_acc[ix] = 0; end
      else if (f3 == 2) begin
        for (int i = 0; i < D; i++) m_acc[i] = 0;
        r = D;
        lat = D + 1;
      end else m_acc[ix] = a;
    end
  endfunction

  // Drives one command and collects its response, optionally holding
  // rsp_ready low for `hold` cycles after rsp_valid rises.
  task automatic do_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] res, output int lat);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    fid = f;
    in0 = a;
    in1 = b;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = rsp_payload;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_payload, res);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic run(input string tag, input logic [9:0] f, input logic [31:0] a,
                     input logic [31:0] b, input int hold);
    logic [31:0] exp_r, got_r;
    int exp_lat, got_lat;
    m_cmd(f, a, b, exp_r, exp_lat);
    do_cmd(f, a, b, hold, got_r, got_lat);
    chk({tag, "_data"}, got_r, exp_r);
    chk({tag, "_lat"}, 32'(got_lat), 32'(exp_lat));
  endtask

  // Call right after reset release at a negedge.
  task automatic wait_init();
    int low = 0;
    int seen = 0;
    for (int i = 1; i <= D; i++) begin
      @(posedge clk);
      #1;
      if (i < D && !cmd_ready) low++;
      if (rsp_valid) seen++;
    end
    chk("init_ready_low", 32'(low), 32'(D - 1));
    chk("init_ready_high", 32'(cmd_ready), 32'd1);
    chk("init_no_rsp", 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [9:0]  f;
    int          pick;

    // Reset state; rsp_ready high during init must be ignored
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_payload", rsp_payload, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    wait_init();
    rsp_ready = 1'b0;

    run("read5", id(3, 0), 32'h0, 32'd5, 0);

    // MAC with default offset
    run("set_filter", id(1, 0), 32'h0101_0101, 32'h0, 0);
    run("mac3_a", id(2, 0), 32'h0, 32'd3, 0);
    run("mac3_b", id(2, 0), 32'h0, 32'd3, 0);
    run("dot_only", id(2, 1), 32'h0, 32'd3, 0);

    // Zero offset, mixed-sign lanes: expect -1
    run("set_off0", id(1, 1), 32'h0, 32'h0, 0);
    run("set_filter2", id(1, 0), 32'hFF02_FF02, 32'h0, 0);
    run("dot_neg", id(2, 1), 32'h7F7F_8080, 32'h0, 0);

    // Overflow, wrap mode then saturate mode
    run("set_filter3", id(1, 0), 32'h0101_0101, 32'h0, 0);
    run("set_off128", id(1, 1), 32'd128, 32'h0, 0);
    run("write7", id(3, 3), 32'h7FFF_FF00, 32'd7, 0);
    run("mac7_wrap", id(2, 0), 32'h0, 32'd7, 0);
    run("status1", id(1, 3), 32'h0, 32'h0, 0);
    run("status0", id(1, 3), 32'h0, 32'h0, 0);
    run("set_sat", id(1, 2), 32'h1, 32'h0, 0);
    run("write7b", id(3, 3), 32'h7FFF_FF00, 32'd7, 0);
    run("mac7_sat", id(2, 0), 32'h0, 32'd7, 0);
    run("mac7_sat2", id(2, 0), 32'h0, 32'd7, 0);
    run("status_sat", id(1, 3), 32'h0, 32'h0, 0);

    // Read-clear, with index upper bits set
    run("rdclr3", id(3, 1), 32'h0, 32'hABCD_0003, 0);
    run("read3", id(3, 0), 32'h0, 32'd3, 0);

    // Randomized mix against the model
    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 10);
      a = $urandom;
      b = $urandom;
      case (pick)
        0, 1: f = id(2, 0);
        2:    f = id(2, 1);
        3:    f = id(3, 0);
        4:    f = id(3, 1);
        5:    f = id(3, 3);
        6:    f = id(1, 0);
        7:    f = id(1, 1);
        8:    f = id(1, 2);
        9:    f = id(1, 3);
        default: f = 10'($urandom_range(0, 1023));
      endcase
      run("rnd", f, a, b, 0);
    end

    // Clear-all: latency, payload, every entry zero
    run("write9", id(3, 3), 32'h1234_5678, 32'd9, 0);
    run("clear_all", id(3, 2), 32'h0, 32'h0, 0);
    for (int i = 0; i < D; i++) run("post_clear_read", id(3, 0), 32'h0, 32'(i), 0);

    // Response held while rsp_ready is low
    run("set_filter4", id(1, 0), 32'h0302_0104, 32'h0, 0);
    run("mac_hold", id(2, 0), 32'h1122_F0E0, 32'd4, 10);

    // Reset during clear-all aborts it; init clear then completes
    run("write12", id(3, 3), 32'hDEAD_BEEF, 32'd12, 0);
    @(negedge clk);
    cmd_valid = 1'b1;
    fid = id(3, 2);
    in0 = 32'h0;
    in1 = 32'h0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    wait_init();
    run("after_rst_read12", id(3, 0), 32'h0, 32'd12, 0);
    run("after_rst_status", id(1, 3), 32'h0, 32'h0, 0);
    run("after_rst_dot", id(2, 1), 32'h5A5A_5A5A, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
